// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Purpose
//   This module is an exhaustive sweep-and-check stage that sits around a
//   combinational gate under test.
//   - It drives every input vector 0 .. 2^N_IN-1 onto o_a, one at a time.
//   - It holds each vector for SETTLE cycles so the gate output can settle.
//   - It then samples i_x for one cycle and compares it against bit o_a of the
//     EXPECT truth table.
//   - At the end of the sweep it reports pass/fail, the mismatch count and
//     the first failing vector.
//
// Parameters
//   N_IN    gate input count, 1..8
//   EXPECT  expected truth table, 2^N_IN bits; bit k is the expected output
//           for input vector k
//   SETTLE  cycles each vector is held before it is sampled, 1..15
//
// Ports
//   i_clk       in   1       rising-edge clock
//   i_rst       in   1       synchronous active-high reset, highest priority
//   i_start     in   1       start a sweep; honoured only in IDLE or DONE
//   o_a         out  N_IN    vector driven to the gate under test
//   i_x         in   1       gate output being checked
//   o_busy      out  1       sweep in progress (DRIVE or SAMPLE)
//   o_done      out  1       sweep finished, results valid
//   o_pass      out  1       last sweep had no mismatch (valid with o_done)
//   o_err_cnt   out  N_IN+1  number of mismatching vectors
//   o_fail_idx  out  N_IN    first mismatching vector (valid if o_err_cnt!=0)
//   o_state     out  2       FSM state, for debug and checker binding
//
// Handshake
//   i_start is a level request. It is consumed on any rising edge where the
//   FSM is in IDLE or DONE, and it is ignored while o_busy=1. o_done stays
//   high, with the results held, until the next accepted i_start or i_rst.
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1110,
  parameter int                    SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic [N_IN-1:0] o_a,
  input  logic            i_x,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic [N_IN-1:0] o_fail_idx,
  output logic [1:0]      o_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // The settle counter counts down from SETTLE-1, so DRIVE lasts SETTLE cycles.
  localparam logic [3:0]      RELOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] A_LAST = {N_IN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] a_q, a_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic            pass_q, pass_d;

  logic            exp_bit;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  // The case-inequality operator makes an X or Z on i_x count as an error,
  // never as a match.
  assign exp_bit  = EXPECT[a_q];
  assign mismatch = (i_x !== exp_bit);
  assign err_nxt  = err_cnt_q + {{N_IN{1'b0}}, mismatch};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_DRIVE;
          a_d        = '0;
          cnt_d      = RELOAD;
          err_cnt_d  = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_nxt;
          // Only the first mismatch is recorded in fail_idx.
          if (err_cnt_q == '0) begin
            fail_idx_d = a_q;
          end
        end
        if (a_q == A_LAST) begin
          // The pass verdict includes the sample taken on this edge.
          state_d = ST_DONE;
          pass_d  = (err_nxt == '0);
        end else begin
          state_d = ST_DRIVE;
          a_d     = a_q + 1'b1;
          cnt_d   = RELOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign o_a        = a_q;
  assign o_busy     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_pass     = pass_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_fail_idx = fail_idx_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// This bench drives two instances of the checker:
//   - dut2 uses the default parameters (2-input OR truth table, SETTLE=1).
//   - dut3 uses N_IN=3, SETTLE=3 and a 3-input AND truth table.
//
// For each DUT the gate under test is a lookup table resp[] indexed by o_a,
// so any gate behaviour can be emulated. The reference model derives the
// expected sweep from the plain rules:
//   - vector v is presented for SETTLE+1 consecutive cycles;
//   - the error count is the number of k with resp[k] != EXPECT[k];
//   - the fail index is the first such k.
// -----------------------------------------------------------------------------
module tb_gate_sweep_checker;

  localparam logic [3:0] EXP2 = 4'b1110;
  localparam logic [7:0] EXP3 = 8'b1000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- dut2 (defaults) ----------------
  logic       start2;
  logic [1:0] a2;
  logic       x2;
  logic       busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] fidx2;
  logic [1:0] st2;
  logic [3:0] resp2;

  assign x2 = resp2[a2];

  gate_sweep_checker dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .o_a(a2), .i_x(x2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_cnt(err2),
    .o_fail_idx(fidx2), .o_state(st2)
  );

  // ---------------- dut3 (N_IN=3, SETTLE=3, AND) ----------------
  logic       start3;
  logic [2:0] a3;
  logic       x3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] fidx3;
  logic [1:0] st3;
  logic [7:0] resp3;

  assign x3 = resp3[a3];

  gate_sweep_checker #(.N_IN(3), .EXPECT(EXP3), .SETTLE(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .o_a(a3), .i_x(x3),
    .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_err_cnt(err3),
    .o_fail_idx(fidx3), .o_state(st3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input int nv, input logic [7:0] tt,
                                input logic [7:0] resp, output int errs,
                                output int first);
    errs  = 0;
    first = 0;
    for (int k = 0; k < nv; k++) begin
      if (resp[k] != tt[k]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
  endfunction

  // ---------------- driver helpers ----------------
  task automatic set_start(input bit sel, input logic v);
    if (sel) start3 = v;
    else     start2 = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    if (sel) begin
      check({tag, "_a3"},    32'(a3),    0);
      check({tag, "_busy3"}, 32'(busy3), 0);
      check({tag, "_done3"}, 32'(done3), 0);
      check({tag, "_pass3"}, 32'(pass3), 0);
      check({tag, "_err3"},  32'(err3),  0);
      check({tag, "_fidx3"}, 32'(fidx3), 0);
    end else begin
      check({tag, "_a2"},    32'(a2),    0);
      check({tag, "_busy2"}, 32'(busy2), 0);
      check({tag, "_done2"}, 32'(done2), 0);
      check({tag, "_pass2"}, 32'(pass2), 0);
      check({tag, "_err2"},  32'(err2),  0);
      check({tag, "_fidx2"}, 32'(fidx2), 0);
    end
  endtask

  // One full sweep on the selected DUT. The sweep starts from IDLE or DONE.
  // If poke is set, i_start is pulsed mid-sweep; the pulse must be ignored.
  task automatic sweep(input bit sel, input logic [7:0] resp, input bit poke);
    logic [7:0] exp_q[$];
    int nv, s1, errs, first, j;
    logic [7:0] tt, v;
    nv = sel ? 8 : 4;
    s1 = sel ? 4 : 2;
    tt = sel ? EXP3 : {4'b0000, EXP2};
    if (sel) resp3 = resp;
    else     resp2 = resp[3:0];
    model(nv, tt, resp, errs, first);
    for (int k = 0; k < nv; k++)
      for (int r = 0; r < s1; r++) exp_q.push_back(8'(k));

    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    j = 0;
    while (exp_q.size() > 0) begin
      if (j > 0) @(negedge clk);
      v = exp_q.pop_front();
      check("a_seq", sel ? 32'(a3) : 32'(a2), 32'(v));
      check("busy",  sel ? 32'(busy3) : 32'(busy2), 1);
      check("done_early", sel ? 32'(done3) : 32'(done2), 0);
      set_start(sel, (poke && j == 2) ? 1'b1 : 1'b0);
      j++;
    end
    @(negedge clk);
    set_start(sel, 1'b0);
    check("done",    sel ? 32'(done3) : 32'(done2), 1);
    check("busy_end", sel ? 32'(busy3) : 32'(busy2), 0);
    check("a_last",  sel ? 32'(a3) : 32'(a2), 32'(nv - 1));
    check("pass",    sel ? 32'(pass3) : 32'(pass2), (errs == 0) ? 1 : 0);
    check("err_cnt", sel ? 32'(err3) : 32'(err2), 32'(errs));
    if (errs != 0)
      check("fail_idx", sel ? 32'(fidx3) : 32'(fidx2), 32'(first));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst    = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    resp2  = 4'b0000;
    resp3  = 8'h00;
    do_reset();
    @(negedge clk);
    check_idle(0, "reset");
    check_idle(1, "reset");

    // T1 OR loopback, T2 AND loopback, T3a stuck-1, T3b stuck-0.
    // Back-to-back sweeps also exercise restart from DONE.
    sweep(0, 8'h0E, 1'b0);
    sweep(0, 8'h08, 1'b0);
    sweep(0, 8'h0F, 1'b0);
    sweep(0, 8'h00, 1'b1);

    // T4: reset mid-sweep, once a fail index has been recorded.
    resp2 = 4'b0000;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_a_nonzero", 32'(a2 != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "abort");
    sweep(0, 8'h0E, 1'b0);

    // Holding i_start re-arms a new sweep on the edge after DONE is entered.
    resp2 = 4'b1110;
    @(negedge clk);
    start2 = 1'b1;
    n = 0;
    while (!done2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", 32'(done2), 1);
    @(negedge clk);
    check("hold_rearm_busy", 32'(busy2), 1);
    check("hold_rearm_a",    32'(a2), 0);
    check("hold_rearm_done", 32'(done2), 0);
    start2 = 1'b0;
    do_reset();

    // Randomized sweeps on the default-parameter instance.
    repeat (6) sweep(0, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // T6: 3-input AND with SETTLE=3, then random tables.
    sweep(1, 8'h80, 1'b0);
    repeat (4) sweep(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
